// File: rtl/ahb_lite_des_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ahb_lite_des_master                                              |
// | Desc    : AHB-Lite initiator running one Triple DES job on the DES slave.  |
// |           Optional macro ERR_ABORT_EN aborts the job on HRESP error.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ahb_lite_des_master #(
   parameter logic [31:0] BASE_ADDR   = 32'hAAAAAAA0,
   parameter int          RESULT_WAIT = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_type,
   input  logic [63:0] req_key1,
   input  logic [63:0] req_key2,
   input  logic [63:0] req_key3,
   input  logic [63:0] req_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_data,
   output logic        res_err,
   input  logic        HREADY,
   input  logic        HRESP,
   input  logic [63:0] HRDATA,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HBURST,
   output logic [2:0]  HSIZE,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic        HSEL,
   output logic [63:0] HWDATA
);

   localparam logic [2:0] c_ST_IDLE     = 3'd0;
   localparam logic [2:0] c_ST_WRITE    = 3'd1;
   localparam logic [2:0] c_ST_LASTDATA = 3'd2;
   localparam logic [2:0] c_ST_WAIT     = 3'd3;
   localparam logic [2:0] c_ST_RD_ADDR  = 3'd4;
   localparam logic [2:0] c_ST_RD_DATA  = 3'd5;
   localparam logic [2:0] c_ST_RD_CAP   = 3'd6;
   localparam logic [2:0] c_ST_RESULT   = 3'd7;

   localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
   localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
   localparam logic [7:0] c_WAIT_INIT    = 8'(RESULT_WAIT - 1);

   logic [2:0]  r_state;
   logic [2:0]  r_idx;
   logic [7:0]  r_cnt;
   logic        r_type;
   logic [63:0] r_key1;
   logic [63:0] r_key2;
   logic [63:0] r_key3;
   logic [63:0] r_data;
   logic [31:0] r_haddr;
   logic        r_hwrite;
   logic [1:0]  r_htrans;
   logic [63:0] r_hwdata;
   logic        r_res_valid;
   logic [63:0] r_res_data;
   logic        r_res_err;
   logic [63:0] w_word;
   logic        w_err;

`ifdef ERR_ABORT_EN
   assign w_err = HRESP && (r_state != c_ST_IDLE) && (r_state != c_ST_RESULT);
`else
   logic w_unused_hresp;
   assign w_unused_hresp = HRESP;
   assign w_err          = 1'b0;
`endif

   // Write data for the address phase that is completing at the current index.
   always_comb begin
      w_word = r_data;
      case (r_idx)
         3'd0:    w_word = {63'd0, r_type};
         3'd1:    w_word = r_key1;
         3'd2:    w_word = r_key2;
         3'd3:    w_word = r_key3;
         default: w_word = r_data;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESET) begin
      if (!HRESET) begin
         r_state     <= c_ST_IDLE;
         r_idx       <= 3'd0;
         r_cnt       <= 8'd0;
         r_type      <= 1'b0;
         r_key1      <= 64'd0;
         r_key2      <= 64'd0;
         r_key3      <= 64'd0;
         r_data      <= 64'd0;
         r_haddr     <= 32'd0;
         r_hwrite    <= 1'b0;
         r_htrans    <= c_TRANS_IDLE;
         r_hwdata    <= 64'd0;
         r_res_valid <= 1'b0;
         r_res_data  <= 64'd0;
         r_res_err   <= 1'b0;
      end else if (w_err) begin
         r_state     <= c_ST_RESULT;
         r_haddr     <= 32'd0;
         r_hwrite    <= 1'b0;
         r_htrans    <= c_TRANS_IDLE;
         r_res_valid <= 1'b1;
         r_res_err   <= 1'b1;
         r_res_data  <= 64'd0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (req_valid) begin
                  r_type   <= req_type;
                  r_key1   <= req_key1;
                  r_key2   <= req_key2;
                  r_key3   <= req_key3;
                  r_data   <= req_data;
                  r_idx    <= 3'd0;
                  r_haddr  <= BASE_ADDR;
                  r_hwrite <= 1'b1;
                  r_htrans <= c_TRANS_NONSEQ;
                  r_state  <= c_ST_WRITE;
               end
            end
            c_ST_WRITE: begin
               if (HREADY) begin
                  r_hwdata <= w_word;
                  if (r_idx == 3'd4) begin
                     r_haddr  <= 32'd0;
                     r_hwrite <= 1'b0;
                     r_htrans <= c_TRANS_IDLE;
                     r_state  <= c_ST_LASTDATA;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_haddr <= BASE_ADDR + {29'd0, r_idx} + 32'd1;
                  end
               end
            end
            c_ST_LASTDATA: begin
               if (HREADY) begin
                  r_cnt   <= c_WAIT_INIT;
                  r_state <= c_ST_WAIT;
               end
            end
            // Cipher latency is counted in raw cycles, independent of HREADY.
            c_ST_WAIT: begin
               if (r_cnt == 8'd0) begin
                  r_haddr  <= BASE_ADDR + 32'd5;
                  r_hwrite <= 1'b0;
                  r_htrans <= c_TRANS_NONSEQ;
                  r_state  <= c_ST_RD_ADDR;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            c_ST_RD_ADDR: begin
               if (HREADY) begin
                  r_haddr  <= 32'd0;
                  r_htrans <= c_TRANS_IDLE;
                  r_state  <= c_ST_RD_DATA;
               end
            end
            c_ST_RD_DATA: begin
               if (HREADY) r_state <= c_ST_RD_CAP;
            end
            // The slave registers its read data one cycle after the data phase.
            c_ST_RD_CAP: begin
               r_res_data  <= HRDATA;
               r_res_valid <= 1'b1;
               r_state     <= c_ST_RESULT;
            end
            c_ST_RESULT: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_res_err   <= 1'b0;
                  r_state     <= c_ST_IDLE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == c_ST_IDLE);
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_err   = r_res_err;
   assign HADDR     = r_haddr;
   assign HWRITE    = r_hwrite;
   assign HTRANS    = r_htrans;
   assign HWDATA    = r_hwdata;
   // The slave errors whenever HSEL=0 with HREADY=1, so HSEL stays high.
   assign HSEL      = 1'b1;
   assign HBURST    = 3'b000;
   assign HSIZE     = 3'b011;
   assign HPROT     = 4'h3;
   assign HMASTLOCK = 1'b0;

endmodule
`default_nettype wire
